// File: rtl/fft_sram_arbiter.sv
// fft_sram_arbiter: shares one single-port FFT ping-buffer SRAM between the
// FFT engine control FSM and a host load/readout port.
//   - Exclusive registered grants. The engine has priority from IDLE.
//   - A hold counter forces a handoff after MAX_HOLD contended beats.
//   - Registered SRAM command outputs (sram_cs/w/addr/wdata).
//   - Read data comes back on the shared rdata bus two cycles after the beat
//     is accepted. It is qualified by eng_rvalid / host_rvalid.
// Ports:
//   clk, rst (async, active-low)
//   eng_req/eng_w/eng_addr/eng_wdata  -> eng_gnt, eng_rvalid
//   host_req/host_w/host_addr/host_wdata -> host_gnt, host_rvalid
//   sram_cs/sram_w/sram_addr/sram_wdata -> SRAM, sram_rdata <- SRAM
//   rdata: combinational pass-through of sram_rdata
module fft_sram_arbiter #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eng_req,
    input  logic          eng_w,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    input  logic          host_req,
    input  logic          host_w,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic          sram_cs,
    output logic          sram_w,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENG  = 2'd1,
        HOST = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          eng_gnt_q, eng_gnt_d;
    logic          host_gnt_q, host_gnt_d;
    logic          sram_cs_q, sram_cs_d;
    logic          sram_w_q, sram_w_d;
    logic [AW-1:0] sram_addr_q, sram_addr_d;
    logic [DW-1:0] sram_wdata_q, sram_wdata_d;
    logic          tag_rd_q, tag_rd_d;
    logic          tag_eng_q, tag_eng_d;
    logic          eng_rvalid_q, eng_rvalid_d;
    logic          host_rvalid_q, host_rvalid_d;

    logic          eng_acc;
    logic          host_acc;

    // A beat is accepted when a requester's req and gnt are both high.
    assign eng_acc  = eng_req & eng_gnt_q;
    assign host_acc = host_req & host_gnt_q;

    // Owner selection and hold counter.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (eng_req) begin
                    state_d = ENG;
                end else if (host_req) begin
                    state_d = HOST;
                end
            end
            ENG: begin
                if (!eng_req) begin
                    state_d = host_req ? HOST : IDLE;
                end else if (host_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = HOST;
                end
            end
            HOST: begin
                if (!host_req) begin
                    state_d = eng_req ? ENG : IDLE;
                end else if (eng_req && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = ENG;
                end
            end
            default: state_d = IDLE;
        endcase

        // Count only the beats taken while the other side is waiting.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
        end else if ((eng_acc && host_req) || (host_acc && eng_req)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end

        eng_gnt_d  = (state_d == ENG);
        host_gnt_d = (state_d == HOST);
    end

    // SRAM command register and read tag pipeline.
    always_comb begin
        sram_cs_d    = eng_acc | host_acc;
        sram_w_d     = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        tag_eng_d    = 1'b0;
        if (eng_acc) begin
            sram_w_d     = eng_w;
            sram_addr_d  = eng_addr;
            sram_wdata_d = eng_wdata;
            tag_eng_d    = 1'b1;
        end else if (host_acc) begin
            sram_w_d     = host_w;
            sram_addr_d  = host_addr;
            sram_wdata_d = host_wdata;
        end
        tag_rd_d      = sram_cs_d & ~sram_w_d;
        // The owner tag travels with the read, so late returns go to the original requester.
        eng_rvalid_d  = tag_rd_q & tag_eng_q;
        host_rvalid_d = tag_rd_q & ~tag_eng_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            eng_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            sram_cs_q     <= 1'b0;
            sram_w_q      <= 1'b0;
            sram_addr_q   <= '0;
            sram_wdata_q  <= '0;
            tag_rd_q      <= 1'b0;
            tag_eng_q     <= 1'b0;
            eng_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            eng_gnt_q     <= eng_gnt_d;
            host_gnt_q    <= host_gnt_d;
            sram_cs_q     <= sram_cs_d;
            sram_w_q      <= sram_w_d;
            sram_addr_q   <= sram_addr_d;
            sram_wdata_q  <= sram_wdata_d;
            tag_rd_q      <= tag_rd_d;
            tag_eng_q     <= tag_eng_d;
            eng_rvalid_q  <= eng_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign eng_gnt     = eng_gnt_q;
    assign host_gnt    = host_gnt_q;
    assign sram_cs     = sram_cs_q;
    assign sram_w      = sram_w_q;
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign eng_rvalid  = eng_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign rdata       = sram_rdata;

endmodule

// File: tb/tb_fft_sram_arbiter.sv
// Bench for fft_sram_arbiter: per-requester command queues feed the DUT.
// A transaction-level model predicts grants, SRAM commands and read returns.
// A simple SRAM model answers the DUT's reads.
module tb_fft_sram_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned MH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          eng_req, eng_w, host_req, host_w;
    logic [AW-1:0] eng_addr, host_addr;
    logic [DW-1:0] eng_wdata, host_wdata;
    logic          eng_gnt, eng_rvalid, host_gnt, host_rvalid;
    logic          sram_cs, sram_w;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata, rdata;

    always #5 clk = ~clk;

    fft_sram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .eng_req(eng_req), .eng_w(eng_w), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
        .host_req(host_req), .host_w(host_w), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .sram_cs(sram_cs), .sram_w(sram_w), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .rdata(rdata)
    );

    // Single-port SRAM: a read in cycle N+1 gives data in N+2.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_w) mem[sram_addr] <= sram_wdata;
            else        sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t eq[$];
    cmd_t hq[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: owner 0=none 1=engine 2=host.
    int            m_owner, m_streak;
    logic          x_cs, x_w;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;
    logic          p1_v, p1_eng, p1_known, p2_v, p2_eng, p2_known;
    logic [DW-1:0] p1_data, p2_data;
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_streak = 0;
        x_cs = 1'b0; x_w = 1'b0; x_addr = '0; x_wdata = '0;
        p1_v = 1'b0; p1_eng = 1'b0; p1_known = 1'b0; p1_data = '0;
        p2_v = 1'b0; p2_eng = 1'b0; p2_known = 1'b0; p2_data = '0;
    endtask

    // Present the head of each queue; idle requesters drive random junk.
    task automatic drive();
        eng_req = (eq.size() != 0);
        if (eng_req) {eng_w, eng_addr, eng_wdata} = eq[0];
        else {eng_w, eng_addr, eng_wdata} = {1'($urandom), AW'($urandom), DW'($urandom)};
        host_req = (hq.size() != 0);
        if (host_req) {host_w, host_addr, host_wdata} = hq[0];
        else {host_w, host_addr, host_wdata} = {1'($urandom), AW'($urandom), DW'($urandom)};
    endtask

    // One clock: check outputs at negedge, advance model, drive next inputs.
    task automatic cycle(output logic acc_rd);
        logic er, hr, ea, ha, mine, other;
        int   nxt, oth;
        cmd_t c;
        @(negedge clk);
        chk("eng_gnt", 64'(eng_gnt), 64'(m_owner == 1));
        chk("host_gnt", 64'(host_gnt), 64'(m_owner == 2));
        chk("sram_cs", 64'(sram_cs), 64'(x_cs));
        chk("sram_w", 64'(sram_w), 64'(x_w));
        chk("sram_addr", 64'(sram_addr), 64'(x_addr));
        chk("sram_wdata", 64'(sram_wdata), 64'(x_wdata));
        chk("eng_rvalid", 64'(eng_rvalid), 64'(p2_v && p2_eng));
        chk("host_rvalid", 64'(host_rvalid), 64'(p2_v && !p2_eng));
        if (p2_v && p2_known) chk("rdata", 64'(rdata), 64'(p2_data));

        er = eng_req; hr = host_req;
        ea = er && (m_owner == 1);
        ha = hr && (m_owner == 2);
        c = '0;
        if (ea) c = eq.pop_front();
        else if (ha) c = hq.pop_front();
        acc_rd = (ea || ha) && !c.w;

        p2_v = p1_v; p2_eng = p1_eng; p2_known = p1_known; p2_data = p1_data;
        p1_v = acc_rd; p1_eng = ea; p1_known = 1'b0;
        if (ea || ha) begin
            x_cs = 1'b1; x_w = c.w; x_addr = c.addr; x_wdata = c.data;
            if (c.w) begin
                mdl_mem[c.addr] = c.data;
                written[c.addr] = 1'b1;
            end else begin
                p1_data  = mdl_mem[c.addr];
                p1_known = written[c.addr];
            end
        end else begin
            x_cs = 1'b0; x_w = 1'b0;
        end

        // Who owns the SRAM next cycle.
        if (m_owner == 0) begin
            nxt = er ? 1 : (hr ? 2 : 0);
        end else begin
            mine  = (m_owner == 1) ? er : hr;
            other = (m_owner == 1) ? hr : er;
            oth   = 3 - m_owner;
            if (!mine) nxt = other ? oth : 0;
            else if (other && (m_streak + 1 == int'(MH))) nxt = oth;
            else nxt = m_owner;
            if (mine && other) m_streak++;
        end
        if (nxt != m_owner) m_streak = 0;
        m_owner = nxt;

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        eq.delete(); hq.delete();
        model_reset();
        repeat (n) begin
            {eng_req, eng_w, host_req, host_w} = 4'($urandom);
            eng_addr = AW'($urandom); host_addr = AW'($urandom);
            eng_wdata = DW'($urandom); host_wdata = DW'($urandom);
            @(negedge clk);
            chk("rst_gnt", 64'({eng_gnt, host_gnt}), 64'(0));
            chk("rst_sram", 64'({sram_cs, sram_w, sram_addr, sram_wdata}), 64'(0));
            chk("rst_rvalid", 64'({eng_rvalid, host_rvalid}), 64'(0));
            chk("rdata_pass", 64'(rdata), 64'(sram_rdata));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        drive();
    endtask

    task automatic drain(input int extra);
        int   budget;
        logic a;
        budget = 400;
        while ((eq.size() != 0 || hq.size() != 0) && budget > 0) begin
            cycle(a);
            budget--;
        end
        chk("drain_timeout", 64'(budget == 0), 64'(0));
        repeat (extra) cycle(a);
    endtask

    initial begin
        logic a;
        int   bud;
        cmd_t c;
        do_reset(3);

        // Host alone after reset.
        hq.push_back('{w: 1'b0, addr: AW'(5), data: '0});
        drive();
        drain(4);

        // Engine writes 0..7 with data addr*3, then reads them back.
        for (int i = 0; i < 8; i++) eq.push_back('{w: 1'b1, addr: AW'(i), data: DW'(i * 3)});
        for (int i = 0; i < 8; i++) eq.push_back('{w: 1'b0, addr: AW'(i), data: '0});
        drive();
        drain(4);

        // Both request from IDLE and stay busy: forced alternation in groups of MH.
        for (int i = 0; i < 12; i++) begin
            eq.push_back('{w: 1'($urandom), addr: AW'(i), data: DW'($urandom)});
            hq.push_back('{w: 1'($urandom), addr: AW'(i + 8), data: DW'($urandom)});
        end
        drive();
        drain(4);

        // Engine drops after two reads while the host waits.
        eq.push_back('{w: 1'b0, addr: AW'(1), data: '0});
        eq.push_back('{w: 1'b0, addr: AW'(2), data: '0});
        for (int i = 0; i < 3; i++) hq.push_back('{w: 1'b1, addr: AW'(20 + i), data: DW'($urandom)});
        drive();
        drain(4);

        // Host dumps the top word written by the engine.
        eq.push_back('{w: 1'b1, addr: AW'(2047), data: 32'hCAFE_0123});
        drive();
        drain(2);
        hq.push_back('{w: 1'b0, addr: AW'(2047), data: '0});
        drive();
        drain(4);

        // Reset asserted the cycle after a read is accepted.
        eq.push_back('{w: 1'b0, addr: AW'(3), data: '0});
        drive();
        a = 1'b0;
        bud = 20;
        while (!a && bud > 0) begin
            cycle(a);
            bud--;
        end
        chk("read_accept_timeout", 64'(a), 64'(1));
        do_reset(2);
        repeat (6) cycle(a);

        // Randomized traffic over a small address window.
        for (int n = 0; n < 800; n++) begin
            if (eq.size() < 3 && ($urandom_range(0, 3) != 0)) begin
                c.w = 1'($urandom); c.addr = AW'($urandom_range(0, 15)); c.data = DW'($urandom);
                eq.push_back(c);
            end
            if (hq.size() < 3 && ($urandom_range(0, 2) != 0)) begin
                c.w = 1'($urandom);
                c.addr = ($urandom_range(0, 9) == 0) ? AW'(2047) : AW'($urandom_range(0, 15));
                c.data = DW'($urandom);
                hq.push_back(c);
            end
            if (!eng_req && !host_req) drive();
            cycle(a);
        end
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_sram_arbiter.md
# fft_sram_arbiter

Arbitrates one single-port working SRAM (the FFT ping buffer) between two requesters: the FFT engine control FSM and a host load/readout port. Grants are registered and exclusive, and the engine has priority. A hold counter bounds how long either side can block the other. Read data returns on a shared bus, qualified by per-requester valid strobes, so the host can preload or dump the buffer between or during butterfly passes without corrupting engine traffic.

## Interface
- AW, 12, SRAM address width
- DW, 32, data width (packed complex word)
- MAX_HOLD, 16, maximum consecutive accepted beats by one owner while the other requests; legal range ≥2

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain only
- eng_req  in  1  engine requests access; command valid
- eng_w  in  1  1 = write, 0 = read
- eng_addr  in  AW  engine address
- eng_wdata  in  DW  engine write data
- eng_gnt  out  1  engine currently owns the SRAM (registered)
- eng_rvalid  out  1  rdata carries engine read result
- host_req, host_w, host_addr, host_wdata  in  1/1/AW/DW  host command, same meaning as the engine fields
- host_gnt  out  1  host owns the SRAM (registered)
- host_rvalid  out  1  rdata carries host read result
- sram_cs  out  1  SRAM chip select (registered)
- sram_w  out  1  SRAM write enable (registered)
- sram_addr  out  AW  SRAM address (registered)
- sram_wdata  out  DW  SRAM write data (registered)
- sram_rdata  in  DW  SRAM read data, valid one cycle after a read cycle
- rdata  out  DW  combinational pass-through of sram_rdata

## Operation
- FSM states:
  - IDLE: eng_gnt = host_gnt = 0
  - ENG: eng_gnt = 1
  - HOST: host_gnt = 1
- A beat is accepted in cycle N when req and gnt of the same requester are both 1 in N.
- Transitions are evaluated every edge:
  - IDLE: eng_req → ENG; else host_req → HOST; else stay. With both requests high, ENG wins.
  - ENG: eng_req = 0 → HOST if host_req, else IDLE.
  - ENG: eng_req = 1, host_req = 1, and hold_cnt == MAX_HOLD−1 on an accepted beat → HOST (forced handoff).
  - ENG: otherwise stay.
  - HOST: mirror image of ENG, with roles swapped.
- hold_cnt (width ceil(log2(MAX_HOLD))+1):
  - increments on each accepted beat while the other requester's req = 1
  - holds its value when the other req = 0
  - clears on every state change
- An accepted beat in cycle N drives sram_cs = 1 with the beat's w, addr and wdata at edge N+1.
- With no accepted beat, sram_cs = 0 and sram_w = 0; addr and wdata hold their last values.
- Read tag pipeline, 2 stages:
  - the stage-1 tag {is_read, owner} is captured with the sram_* registers
  - stage 2 asserts eng_rvalid or host_rvalid in cycle N+2
- A requester keeps req, w, addr and wdata stable until it sees its own gnt; once granted, it may change them every cycle (streaming).
- Losing gnt mid-burst drops nothing already accepted. Outstanding reads still return, tagged to their original owner.

## Timing
- Reset (rst = 0, async) forces:
  - state IDLE, hold_cnt 0, both gnt 0
  - sram_cs, sram_w, sram_addr, sram_wdata all 0
  - tag pipeline cleared, so both rvalid = 0
  - rdata follows sram_rdata
- Grant latency from IDLE: req seen at edge E, gnt high after E, first beat accepted in the next cycle.
- Owner switch (ENG↔HOST) has zero dead cycles: the new gnt is high in the cycle immediately after the last old-owner beat.
- Write latency: accepted in N, SRAM written at the edge ending N+1.
- Read latency: accepted in N, rvalid and rdata in N+2. Sustained throughput is 1 beat/cycle.
- Reset asserted mid-operation discards any in-flight read; no rvalid appears after reset release.
- eng_gnt & host_gnt is never 1 in the same cycle. At most one rvalid is high per cycle.

## Test plan
- Reset: drive rst = 0 with random requests active → all outputs 0. Release; host_req = 1 → host_gnt rises 1 cycle later and eng_gnt stays 0.
- Engine write-then-read stream, host idle: eng_req held, writes to addr 0..7 (data = addr·3), then reads 0..7 → sram_w/sram_addr follow 1 cycle behind the beats; eng_rvalid in cycles N+2 returns 0,3,…,21 back-to-back.
- Simultaneous request from IDLE: both req = 1 in the same cycle → ENG granted first. With MAX_HOLD = 4 and both held, the pattern is exactly 4 engine beats, then 4 host beats, repeating, with no gaps.
- Owner drop: in ENG, eng_req falls while host_req = 1 → host_gnt is high the very next cycle, and the engine's two outstanding reads still return on eng_rvalid.
- Host dump during engine idle: host reads addr 2047 → host_rvalid 2 cycles later with the correct word; eng_rvalid stays 0 throughout.
- Reset mid-read: assert rst one cycle after a read beat is accepted → no rvalid after release, and the FSM is back in IDLE.
